floor_datapath: RTL and testbench

Elevator datapath stage that sits beside the `FMS` controller. It holds the pending call register, current floor, destination floor, direction and per-floor travel timer. It produces the controller's `comparator_result` and `input_bool` inputs and consumes its `oinput_en`, `oupdate_*`, `rst_des_en` and `is_move` strobes.

---
 rtl/floor_datapath.sv | 80 ++++++++
 tb/tb_floor_datapath.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/floor_datapath.sv
// floor_datapath: elevator request latch, destination select, floor position and travel timer
// Sits beside the FMS controller, feeding it comparator_result and input_bool.
module floor_datapath #(
   parameter int FLOORS      = 8,
   parameter int FLOOR_W     = 3,
   parameter int MOVE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               irst,
   input  logic [FLOORS-1:0]  call_btn,
   input  logic               input_en,
   input  logic               update_dir,
   input  logic               update_dir_en,
   input  logic               update_des_en,
   input  logic               update_now_en,
   input  logic               rst_des_en,
   input  logic               is_move,
   output logic [2:0]         comparator_result,
   output logic               input_bool,
   output logic [FLOOR_W-1:0] now_floor,
   output logic [FLOOR_W-1:0] des_floor,
   output logic               dir,
   output logic [FLOORS-1:0]  pending,
   output logic               floor_tick
);
   localparam int TW = MOVE_CYCLES > 1 ? $clog2(MOVE_CYCLES) : 1;
   localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(FLOORS - 1);
   logic [TW-1:0]      timer;
   logic [FLOOR_W-1:0] up_ge, up_lt, dn_le, dn_gt, sel;
   logic               f_up_ge, f_dn_le, tc;
   logic [FLOORS-1:0]  clr;
   // Descending scan leaves the lowest match, ascending scan the highest
   always_comb begin
      up_ge = '0;
      dn_gt = '0;
      up_lt = '0;
      dn_le = '0;
      f_up_ge = 1'b0;
      f_dn_le = 1'b0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && FLOOR_W'(i) >= now_floor) begin
            up_ge = FLOOR_W'(i);
            f_up_ge = 1'b1;
         end
         if (pending[i] && FLOOR_W'(i) > now_floor) dn_gt = FLOOR_W'(i);
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (pending[i] && FLOOR_W'(i) < now_floor) up_lt = FLOOR_W'(i);
         if (pending[i] && FLOOR_W'(i) <= now_floor) begin
            dn_le = FLOOR_W'(i);
            f_dn_le = 1'b1;
         end
      end
      sel = (pending == '0) ? now_floor : dir ? (f_up_ge ? up_ge : up_lt) : (f_dn_le ? dn_le : dn_gt);
      clr = rst_des_en ? (FLOORS'(1) << now_floor) : '0;
      tc = is_move && (timer == TW'(MOVE_CYCLES - 1));
   end
   assign floor_tick = tc & update_now_en;
   assign input_bool = |pending;
   assign comparator_result = {des_floor > now_floor, des_floor == now_floor, des_floor < now_floor};
   always_ff @(posedge clk) begin
      if (irst) begin
         now_floor <= '0;
         des_floor <= '0;
         dir       <= 1'b1;
         pending   <= '0;
         timer     <= '0;
      end else begin
         pending <= (pending | (input_en ? call_btn : '0)) & ~clr;
         if (update_dir_en) dir <= update_dir;
         if (update_des_en) des_floor <= sel;
         if (floor_tick) begin
            now_floor <= dir ? ((now_floor == TOP) ? now_floor : now_floor + 1'b1)
                             : ((now_floor == '0) ? now_floor : now_floor - 1'b1);
            timer <= '0;
         end else if (!is_move) timer <= '0;
         else if (!tc) timer <= timer + 1'b1;
      end
   end
endmodule

// File: tb/tb_floor_datapath.sv
// tb_floor_datapath: directed stimulus with a scan-based reference model checked every cycle
module tb_floor_datapath;
   localparam int F = 8;
   localparam int MC = 4;
   logic clk = 0, irst = 1;
   logic [F-1:0] call_btn = '0;
   logic input_en = 0, update_dir = 0, update_dir_en = 0, update_des_en = 0;
   logic update_now_en = 0, rst_des_en = 0, is_move = 0;
   logic [2:0] comparator_result;
   logic input_bool, dir, floor_tick;
   logic [2:0] now_floor, des_floor;
   logic [F-1:0] pending;
   int total = 0, bad = 0;
   bit en = 0;
   int m_now = 0, m_des = 0, m_timer = 0;
   bit m_dir = 1;
   bit [F-1:0] m_pend = '0;

   floor_datapath #(.FLOORS(F), .FLOOR_W(3), .MOVE_CYCLES(MC)) dut (
      .clk(clk), .irst(irst), .call_btn(call_btn), .input_en(input_en),
      .update_dir(update_dir), .update_dir_en(update_dir_en), .update_des_en(update_des_en),
      .update_now_en(update_now_en), .rst_des_en(rst_des_en), .is_move(is_move),
      .comparator_result(comparator_result), .input_bool(input_bool), .now_floor(now_floor),
      .des_floor(des_floor), .dir(dir), .pending(pending), .floor_tick(floor_tick));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Walk from the current floor in the travel direction, then turn around
   function automatic int pick(input int now, input bit d, input bit [F-1:0] p);
      if (p == 0) return now;
      if (d) begin
         for (int f = now; f < F; f++) if (p[f]) return f;
         for (int f = now - 1; f >= 0; f--) if (p[f]) return f;
      end else begin
         for (int f = now; f >= 0; f--) if (p[f]) return f;
         for (int f = now + 1; f < F; f++) if (p[f]) return f;
      end
      return now;
   endfunction

   always @(posedge clk) begin
      bit [F-1:0] np;
      bit tc;
      if (irst) begin
         m_now = 0; m_des = 0; m_dir = 1; m_pend = '0; m_timer = 0;
      end else begin
         tc = is_move && m_timer == MC - 1;
         if (update_des_en) m_des = pick(m_now, m_dir, m_pend);
         np = m_pend | (input_en ? call_btn : '0);
         if (rst_des_en) np[m_now] = 1'b0;
         if (tc && update_now_en) begin
            m_now = m_dir ? (m_now < F - 1 ? m_now + 1 : m_now) : (m_now > 0 ? m_now - 1 : 0);
            m_timer = 0;
         end else if (!is_move) m_timer = 0;
         else if (!tc) m_timer++;
         m_pend = np;
         if (update_dir_en) m_dir = update_dir;
      end
   end

   always @(negedge clk) if (en) begin
      chk("m_now", now_floor, m_now);
      chk("m_des", des_floor, m_des);
      chk("m_dir", dir, m_dir);
      chk("m_pend", pending, m_pend);
      chk("m_cmp", comparator_result, m_des > m_now ? 4 : m_des == m_now ? 2 : 1);
      chk("m_ib", input_bool, m_pend != 0);
      chk("m_tick", floor_tick, is_move && update_now_en && m_timer == MC - 1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic idle();
      call_btn = '0; input_en = 0; update_dir_en = 0; update_des_en = 0;
      update_now_en = 0; rst_des_en = 0; is_move = 0;
   endtask

   task automatic travel(input int k);
      is_move = 1; update_now_en = 1;
      cyc(MC * k);
      is_move = 0; update_now_en = 0;
   endtask

   task automatic set_dir(input bit d);
      update_dir = d; update_dir_en = 1;
      cyc(1);
      update_dir_en = 0;
   endtask

   task automatic pulse_des();
      update_des_en = 1;
      cyc(1);
      update_des_en = 0;
   endtask

   task automatic clear_here();
      rst_des_en = 1;
      cyc(1);
      rst_des_en = 0;
   endtask

   initial begin
      cyc(1);
      en = 1;
      irst = 0;
      input_en = 1; call_btn = 8'hff; update_dir = 0; update_dir_en = 1; update_des_en = 1;
      cyc(1);
      is_move = 1; update_now_en = 1;
      cyc(2);
      irst = 1;
      cyc(1);
      irst = 0; idle();
      chk("rst_now", now_floor, 0);
      chk("rst_des", des_floor, 0);
      chk("rst_dir", dir, 1);
      chk("rst_pend", pending, 8'h00);
      chk("rst_cmp", comparator_result, 3'b010);
      chk("rst_ib", input_bool, 0);
      call_btn = 8'h20;
      cyc(1);
      chk("gate_off", pending, 8'h00);
      input_en = 1;
      cyc(1);
      chk("gate_on", pending, 8'h20);
      chk("gate_ib", input_bool, 1);
      call_btn = 8'h04;
      cyc(1);
      idle();
      chk("pend24", pending, 8'h24);
      pulse_des();
      chk("sel_des2", des_floor, 2);
      chk("sel_cmp", comparator_result, 3'b100);
      is_move = 1; update_now_en = 1;
      cyc(MC - 1);
      chk("tick1", floor_tick, 1);
      chk("pre_step", now_floor, 0);
      cyc(1);
      chk("step1", now_floor, 1);
      cyc(MC - 1);
      chk("tick2", floor_tick, 1);
      cyc(1);
      idle();
      chk("step2", now_floor, 2);
      chk("arrive_cmp", comparator_result, 3'b010);
      clear_here();
      chk("clr_pend", pending, 8'h20);
      pulse_des();
      chk("des5", des_floor, 5);
      travel(3);
      chk("at5", now_floor, 5);
      clear_here();
      chk("ib_fall", input_bool, 0);
      input_en = 1; call_btn = 8'h40;
      set_dir(0);
      idle();
      pulse_des();
      chk("dn_fallback", des_floor, 6);
      chk("dn_cmp", comparator_result, 3'b100);
      set_dir(1);
      travel(1);
      clear_here();
      set_dir(0);
      travel(1);
      chk("back5", now_floor, 5);
      input_en = 1; call_btn = 8'h0A;
      set_dir(1);
      idle();
      pulse_des();
      chk("up_fallback", des_floor, 3);
      chk("up_fb_cmp", comparator_result, 3'b001);
      set_dir(0);
      travel(2);
      chk("at3", now_floor, 3);
      input_en = 1; call_btn = 8'h09; rst_des_en = 1;
      cyc(1);
      idle();
      chk("collision", pending, 8'h03);
      set_dir(1);
      travel(4);
      chk("at7", now_floor, 7);
      is_move = 1; update_now_en = 1;
      cyc(MC - 1);
      chk("sat_tick", floor_tick, 1);
      cyc(1);
      chk("sat_hold", now_floor, 7);
      update_now_en = 0;
      cyc(MC - 1);
      chk("hold_tick0", floor_tick, 0);
      cyc(3);
      chk("hold_tick0b", floor_tick, 0);
      chk("hold_now", now_floor, 7);
      update_now_en = 1;
      #1;
      chk("held_terminal", floor_tick, 1);
      is_move = 0; update_now_en = 0;
      cyc(1);
      is_move = 1; update_now_en = 1;
      #1;
      chk("timer_zeroed", floor_tick, 0);
      cyc(MC - 1);
      chk("timer_recount", floor_tick, 1);
      irst = 1;
      cyc(1);
      irst = 0; idle();
      chk("midrst_now", now_floor, 0);
      chk("midrst_pend", pending, 8'h00);
      set_dir(0);
      travel(1);
      chk("sat_low", now_floor, 0);
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
